// File: rtl/pcs_pkg.sv
// Shared definitions for the PCS transmit path: K28.5 idle constants,
// serializer state encoding and a 10-bit popcount helper.
`timescale 1ns/1ps
package pcs_pkg;

    localparam logic [9:0] K28_5_RDN = 10'h17C;
    localparam logic [9:0] K28_5_RDP = 10'h283;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_SYNC = 2'd1,
        ST_RUN  = 2'd2
    } pcs_state_e;

    function automatic logic [3:0] popcount10(input logic [9:0] sym);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 10; i++) begin
            cnt = cnt + {3'b000, sym[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/pcs_disparity_tracker.sv
// Running-disparity tracker for 10-bit code-groups; updates RD on every load
// and flags data symbols whose popcount cannot be a legal 8b/10b code.
`timescale 1ns/1ps
module pcs_disparity_tracker (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       is_data,
    input  logic       clear,
    input  logic [9:0] sym,
    output logic       rd_pos,
    output logic       disp_err
);
    import pcs_pkg::*;

    logic [3:0] ones;

    assign ones = popcount10(sym);

    // Balanced (5) and illegal weights leave RD alone; only data symbols raise an error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pos   <= 1'b0;
            disp_err <= 1'b0;
        end else begin
            disp_err <= 1'b0;
            if (load) begin
                case (ones)
                    4'd6:    rd_pos <= 1'b1;
                    4'd4:    rd_pos <= 1'b0;
                    4'd5:    rd_pos <= rd_pos;
                    default: disp_err <= is_data;
                endcase
            end else if (clear) begin
                rd_pos <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pcs_tx_serializer.sv
// Link-domain TX serializer: pops 10-bit code-groups from the CDC FIFO and
// shifts them out LSB first, filling gaps and start-up with K28.5 commas.
`timescale 1ns/1ps
module pcs_tx_serializer #(
    parameter int DATA_WIDTH = 10,
    parameter int SYNC_SYMS  = 4,
    parameter int UNDERRUN_W = 16
) (
    input  logic                  clk_link,
    input  logic                  rst_n_link,
    input  logic                  tx_en,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    output logic                  tx_serial,
    output logic                  sym_start,
    output logic                  sym_is_data,
    output logic                  rd_pos,
    output logic                  link_active,
    output logic                  disp_err,
    output logic [UNDERRUN_W-1:0] underrun_cnt
);
    import pcs_pkg::*;

    localparam int SYNC_W = $clog2(SYNC_SYMS + 1);

    pcs_state_e        state;
    pcs_state_e        state_next;
    logic [9:0]        shreg;
    logic [3:0]        bit_cnt;
    logic [SYNC_W-1:0] sync_cnt;

    logic       boundary;
    logic       load;
    logic       load_data;
    logic       run_load;
    logic       go_off;
    logic       sync_start;
    logic       sync_inc;
    logic       underrun_inc;
    logic       rd_clear;
    logic [9:0] idle_sym;
    logic [9:0] load_sym;

    assign boundary    = (bit_cnt == 4'd9);
    assign idle_sym    = rd_pos ? K28_5_RDP : K28_5_RDN;
    assign tx_serial   = shreg[0];
    assign link_active = (state == ST_SYNC) || (state == ST_RUN);
    assign rd_clear    = go_off || ((state == ST_OFF) && !load);

    // Decisions are only taken in OFF or on the last bit of a symbol, so a
    // symbol in flight always completes and symbols stay back-to-back.
    always_comb begin
        state_next   = state;
        load         = 1'b0;
        load_data    = 1'b0;
        run_load     = 1'b0;
        go_off       = 1'b0;
        sync_start   = 1'b0;
        sync_inc     = 1'b0;
        underrun_inc = 1'b0;
        fifo_rd_en   = 1'b0;
        load_sym     = idle_sym;

        case (state)
            ST_OFF: begin
                if (tx_en) begin
                    load       = 1'b1;
                    load_sym   = K28_5_RDN;
                    sync_start = 1'b1;
                    state_next = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (boundary) begin
                    if (!tx_en) begin
                        go_off     = 1'b1;
                        state_next = ST_OFF;
                    end else if (sync_cnt < SYNC_W'(SYNC_SYMS)) begin
                        load     = 1'b1;
                        sync_inc = 1'b1;
                    end else begin
                        run_load   = 1'b1;
                        state_next = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (boundary) begin
                    if (!tx_en) begin
                        go_off     = 1'b1;
                        state_next = ST_OFF;
                    end else begin
                        run_load = 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_OFF;
            end
        endcase

        if (run_load) begin
            load = 1'b1;
            if (!fifo_empty) begin
                fifo_rd_en = 1'b1;
                load_data  = 1'b1;
                load_sym   = fifo_data;
            end else begin
                underrun_inc = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_link or negedge rst_n_link) begin
        if (!rst_n_link) begin
            state <= ST_OFF;
        end else begin
            state <= state_next;
        end
    end

    // Shift register, symbol flags and counters; leaving the link clears the line.
    always_ff @(posedge clk_link or negedge rst_n_link) begin
        if (!rst_n_link) begin
            shreg        <= 10'd0;
            bit_cnt      <= 4'd0;
            sync_cnt     <= '0;
            sym_start    <= 1'b0;
            sym_is_data  <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            sym_start <= load;
            if (load) begin
                shreg       <= load_sym;
                bit_cnt     <= 4'd0;
                sym_is_data <= load_data;
            end else if (go_off) begin
                shreg       <= 10'd0;
                bit_cnt     <= 4'd0;
                sym_is_data <= 1'b0;
            end else if (state != ST_OFF) begin
                shreg   <= {1'b0, shreg[9:1]};
                bit_cnt <= bit_cnt + 4'd1;
            end

            if (sync_start) begin
                sync_cnt <= SYNC_W'(1);
            end else if (sync_inc) begin
                sync_cnt <= sync_cnt + SYNC_W'(1);
            end

            if (underrun_inc && (underrun_cnt != {UNDERRUN_W{1'b1}})) begin
                underrun_cnt <= underrun_cnt + UNDERRUN_W'(1);
            end
        end
    end

    pcs_disparity_tracker u_disparity (
        .clk      (clk_link),
        .rst_n    (rst_n_link),
        .load     (load),
        .is_data  (load_data),
        .clear    (rd_clear),
        .sym      (load_sym),
        .rd_pos   (rd_pos),
        .disp_err (disp_err)
    );

endmodule

// File: tb/tb_pcs_tx_serializer.sv
// Self-checking bench for pcs_tx_serializer against a symbol/bit-queue model
// of the transmit line, with directed phases followed by random traffic.
`timescale 1ns/1ps
module tb_pcs_tx_serializer;

    localparam int SYNC = 4;
    localparam int UW   = 4;
    localparam int UMAX = (1 << UW) - 1;

    logic          clk_link;
    logic          rst_n_link;
    logic          tx_en;
    logic [9:0]    fifo_data;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic          tx_serial;
    logic          sym_start;
    logic          sym_is_data;
    logic          rd_pos;
    logic          link_active;
    logic          disp_err;
    logic [UW-1:0] underrun_cnt;

    int total;
    int bad;

    logic [9:0] fifo_q[$];
    bit         line_q[$];
    bit         m_active;
    bit         m_run;
    bit         m_rd;
    bit         m_is_data;
    bit         m_start;
    bit         m_derr;
    bit         m_pop;
    bit         last_pop;
    int         m_sync;
    int         m_under;

    pcs_tx_serializer #(
        .DATA_WIDTH (10),
        .SYNC_SYMS  (SYNC),
        .UNDERRUN_W (UW)
    ) dut (
        .clk_link     (clk_link),
        .rst_n_link   (rst_n_link),
        .tx_en        (tx_en),
        .fifo_data    (fifo_data),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .tx_serial    (tx_serial),
        .sym_start    (sym_start),
        .sym_is_data  (sym_is_data),
        .rd_pos       (rd_pos),
        .link_active  (link_active),
        .disp_err     (disp_err),
        .underrun_cnt (underrun_cnt)
    );

    initial clk_link = 1'b0;
    always #5 clk_link = ~clk_link;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic modelReset();
        line_q.delete();
        m_active  = 0;
        m_run     = 0;
        m_rd      = 0;
        m_is_data = 0;
        m_start   = 0;
        m_derr    = 0;
        m_pop     = 0;
        m_sync    = 0;
        m_under   = 0;
    endtask

    // A symbol goes on the line: queue its bits a..j and apply the RD rules.
    task automatic modelLoad(input logic [9:0] sym, input bit is_data);
        int ones;
        ones = $countones(sym);
        line_q.delete();
        for (int i = 0; i < 10; i++) line_q.push_back(sym[i]);
        m_start   = 1;
        m_is_data = is_data;
        if (ones == 6)      m_rd = 1;
        else if (ones == 4) m_rd = 0;
        else if (ones != 5 && is_data) m_derr = 1;
    endtask

    // What the line does at the coming clock edge, given the current inputs.
    task automatic modelEdge();
        logic [9:0] idle;
        idle    = m_rd ? 10'h283 : 10'h17C;
        m_pop   = 0;
        m_start = 0;
        m_derr  = 0;
        if (!m_active) begin
            m_rd = 0;
            if (tx_en) begin
                modelLoad(10'h17C, 0);
                m_sync   = 1;
                m_active = 1;
                m_run    = 0;
            end
        end else if (line_q.size() == 1) begin
            if (!tx_en) begin
                m_active  = 0;
                m_run     = 0;
                m_rd      = 0;
                m_is_data = 0;
                line_q.delete();
            end else if (!m_run && m_sync < SYNC) begin
                modelLoad(idle, 0);
                m_sync++;
            end else begin
                m_run = 1;
                if (fifo_q.size() > 0) begin
                    m_pop = 1;
                    modelLoad(fifo_q[0], 1);
                end else begin
                    modelLoad(idle, 0);
                    if (m_under < UMAX) m_under++;
                end
            end
        end else begin
            void'(line_q.pop_front());
        end
    endtask

    // One link cycle: check registered outputs, update FIFO/enable, predict the edge.
    task automatic applyStimulus(input bit en, input bit push, input logic [9:0] val);
        bit exp_tx;
        @(negedge clk_link);
        exp_tx = (m_active && line_q.size() > 0) ? line_q[0] : 1'b0;
        checkOutput("tx_serial",    32'(tx_serial),    32'(exp_tx));
        checkOutput("sym_start",    32'(sym_start),    32'(m_start));
        checkOutput("sym_is_data",  32'(sym_is_data),  32'(m_is_data));
        checkOutput("rd_pos",       32'(rd_pos),       32'(m_rd));
        checkOutput("link_active",  32'(link_active),  32'(m_active));
        checkOutput("disp_err",     32'(disp_err),     32'(m_derr));
        checkOutput("underrun_cnt", 32'(underrun_cnt), 32'(m_under));
        if (last_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
        if (push) fifo_q.push_back(val);
        tx_en      = en;
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = (fifo_q.size() > 0) ? fifo_q[0] : 10'h000;
        #1;
        modelEdge();
        checkOutput("fifo_rd_en", 32'(fifo_rd_en), 32'(m_pop));
        last_pop = fifo_rd_en;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_tx_serial"},    32'(tx_serial),    0);
        checkOutput({tag, "_sym_start"},    32'(sym_start),    0);
        checkOutput({tag, "_sym_is_data"},  32'(sym_is_data),  0);
        checkOutput({tag, "_rd_pos"},       32'(rd_pos),       0);
        checkOutput({tag, "_link_active"},  32'(link_active),  0);
        checkOutput({tag, "_disp_err"},     32'(disp_err),     0);
        checkOutput({tag, "_underrun_cnt"}, 32'(underrun_cnt), 0);
        checkOutput({tag, "_fifo_rd_en"},   32'(fifo_rd_en),   0);
    endtask

    initial begin
        bit         en;
        bit         found;
        logic [9:0] rnd;
        total      = 0;
        bad        = 0;
        last_pop   = 0;
        rst_n_link = 1'b0;
        tx_en      = 1'b0;
        fifo_empty = 1'b1;
        fifo_data  = 10'h000;
        modelReset();

        repeat (3) @(negedge clk_link);
        checkAllZero("reset");
        rst_n_link = 1'b1;

        $display("[TB] start-up commas and RUN underruns");
        repeat (90) applyStimulus(1, 0, 10'h000);

        $display("[TB] two balanced data symbols back to back");
        applyStimulus(1, 1, 10'h2AA);
        applyStimulus(1, 1, 10'h0F8);
        repeat (40) applyStimulus(1, 0, 10'h000);

        $display("[TB] data arriving mid-idle");
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (m_run && !m_is_data && line_q.size() == 7) found = 1;
            else applyStimulus(1, 0, 10'h000);
        end
        if (!found) checkOutput("wait_idle_bit3", 0, 1);
        applyStimulus(1, 1, 10'h1B5);
        repeat (30) applyStimulus(1, 0, 10'h000);

        $display("[TB] disparity flip and illegal weight");
        applyStimulus(1, 1, 10'h3F0);
        repeat (25) applyStimulus(1, 0, 10'h000);
        applyStimulus(1, 1, 10'h3FF);
        repeat (25) applyStimulus(1, 0, 10'h000);

        $display("[TB] tx_en dropped inside a data symbol");
        applyStimulus(1, 1, 10'h2AA);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (m_is_data && line_q.size() == 8) found = 1;
            else applyStimulus(1, 0, 10'h000);
        end
        if (!found) checkOutput("wait_data_bit2", 0, 1);
        repeat (25) applyStimulus(0, 0, 10'h000);

        $display("[TB] random traffic");
        en = 1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) en = ~en;
            rnd = 10'($urandom_range(0, 1023));
            applyStimulus(en, (fifo_q.size() < 8) && ($urandom_range(0, 11) == 0), rnd);
        end

        $display("[TB] underrun saturation");
        repeat (250) applyStimulus(1, 0, 10'h000);
        checkOutput("underrun_sat", 32'(underrun_cnt), UMAX);

        $display("[TB] reset mid-symbol");
        @(posedge clk_link);
        #3;
        rst_n_link = 1'b0;
        #1;
        checkAllZero("midreset");
        tx_en = 1'b0;
        modelReset();
        @(negedge clk_link);
        rst_n_link = 1'b1;
        repeat (30) applyStimulus(1, 0, 10'h000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
